// File: rtl/fifo_pkg.sv
// Shared defaults, the pointer/count type and the depth helper for the sync FIFO family.
package fifo_pkg;

  localparam int DATA_DEF = 8;
  localparam int ADDR_DEF = 4;

  // One extra MSB beyond the address is the wrap bit that separates full from empty.
  typedef logic [ADDR_DEF:0] ptr_t;

  function automatic int depth(input int addr);
    return 1 << addr;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array for sync_fifo_ctrl.
// SYNC_FIFO_FWFT_EN makes the read port combinational, otherwise it is registered.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA = DATA_DEF,
  parameter int ADDR = ADDR_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic [ADDR-1:0] waddr,
  input  logic [DATA-1:0] wdata,
  input  logic            re,
  input  logic [ADDR-1:0] raddr,
  output logic [DATA-1:0] rdata
);

  logic [DATA-1:0] mem [0:depth(ADDR)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  logic unused_rd_ctrl;

  assign rdata          = mem[raddr];
  assign unused_rd_ctrl = rstn ^ re;
`else
  // Only the output register is cleared; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA = DATA_DEF,
  parameter int ADDR = ADDR_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            winc,
  input  logic [DATA-1:0] wdata,
  input  logic            rinc,
  input  logic [ADDR:0]   afull_thr,
  input  logic [ADDR:0]   aempty_thr,
  input  logic            clr_err,
  output logic [DATA-1:0] rdata,
  output logic            wfull,
  output logic            rempty,
  output logic            walmost_full,
  output logic            ralmost_empty,
  output logic [ADDR:0]   count,
  output logic            overflow,
  output logic            underflow
);

  // Handshake: a write transfers on a posedge where winc && !wfull, a read where
  // rinc && !rempty. Requests against a full/empty FIFO are dropped and flagged.
  logic [ADDR:0] wptr, rptr, wptr_nxt, rptr_nxt, cnt_q;
  logic          wr_ok, rd_ok;

  assign rempty = (wptr == rptr);
  assign wfull  = (wptr[ADDR] != rptr[ADDR]) && (wptr[ADDR-1:0] == rptr[ADDR-1:0]);

  assign wr_ok = winc && !wfull;
  assign rd_ok = rinc && !rempty;

  assign wptr_nxt = wptr + {{ADDR{1'b0}}, wr_ok};
  assign rptr_nxt = rptr + {{ADDR{1'b0}}, rd_ok};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr      <= '0;
      rptr      <= '0;
      cnt_q     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      cnt_q     <= wptr_nxt - rptr_nxt;
      // A new error in the same cycle as clr_err leaves the flag set.
      overflow  <= (overflow && !clr_err) || (winc && wfull);
      underflow <= (underflow && !clr_err) || (rinc && rempty);
    end
  end

  assign count = cnt_q;

  // Thresholds above DEPTH fall out naturally since count never exceeds DEPTH.
  assign walmost_full  = (cnt_q >= afull_thr);
  assign ralmost_empty = (cnt_q <= aempty_thr);

  fifo_mem #(
    .DATA (DATA),
    .ADDR (ADDR)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_ok && rstn),
    .waddr (wptr[ADDR-1:0]),
    .wdata (wdata),
    .re    (rd_ok && rstn),
    .raddr (rptr[ADDR-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: directed vectors, read-data scoreboard, flag checks.
module tb_sync_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DATA  = 8;
  localparam int ADDR  = 4;
  localparam int DEPTH = 16;

  logic            clk;
  logic            rstn;
  logic            winc;
  logic [DATA-1:0] wdata;
  logic            rinc;
  logic [ADDR:0]   afull_thr;
  logic [ADDR:0]   aempty_thr;
  logic            clr_err;
  logic [DATA-1:0] rdata;
  logic            wfull;
  logic            rempty;
  logic            walmost_full;
  logic            ralmost_empty;
  logic [ADDR:0]   count;
  logic            overflow;
  logic            underflow;

  sync_fifo_ctrl #(
    .DATA (DATA),
    .ADDR (ADDR)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .winc          (winc),
    .wdata         (wdata),
    .rinc          (rinc),
    .afull_thr     (afull_thr),
    .aempty_thr    (aempty_thr),
    .clr_err       (clr_err),
    .rdata         (rdata),
    .wfull         (wfull),
    .rempty        (rempty),
    .walmost_full  (walmost_full),
    .ralmost_empty (ralmost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  int              n_chk  = 0;
  int              n_pass = 0;
  int              m_cnt  = 0;
  ptr_t            m_cnt_p;
  logic            exp_rd = 1'b0;
  logic [DATA-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One cycle of stimulus, issued at a negedge; returns at the following negedge.
  task automatic drive(input logic w, input logic [DATA-1:0] d, input logic r, input logic ce);
    bit wa, ra;
    wa = w && (m_cnt < DEPTH) && rstn;
    ra = r && (m_cnt > 0) && rstn;
    winc    = w;
    wdata   = d;
    rinc    = r;
    clr_err = ce;
    exp_rd  = ra;
    if (wa) exp_q.push_back(d);
    m_cnt   = m_cnt + int'(wa) - int'(ra);
    m_cnt_p = ptr_t'(m_cnt);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    m_cnt = 0;
    exp_q.delete();
  endtask

  // monitor: pops one expected word per read the model says was accepted
  initial begin : monitor
    logic            fire;
    logic [DATA-1:0] got;
    logic [DATA-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      fire = exp_rd;
`ifdef SYNC_FIFO_FWFT_EN
      got = rdata;
      @(posedge clk);
      #1;
`else
      @(posedge clk);
      #1;
      got = rdata;
`endif
      if (fire) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rdata_underrun: read with no expected word queued, got %0d", got);
        end else begin
          e = exp_q.pop_front();
          check("rdata", int'(got), int'(e));
        end
      end
    end
  end

  initial begin : stim
    rstn       = 1'b0;
    winc       = 1'b0;
    wdata      = '0;
    rinc       = 1'b0;
    clr_err    = 1'b0;
    afull_thr  = '0;
    aempty_thr = '0;
    @(negedge clk);

    // 1. reset / idle
    repeat (3) idle();
    rstn = 1'b1;
    model_reset();
    check("rst_rempty", rempty, 1);
    check("rst_wfull", wfull, 0);
    check("rst_count", count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    check("rst_rdata", rdata, 0);
    check("rst_afull_thr0", walmost_full, 1);
    check("rst_aempty", ralmost_empty, 1);
    idle();
    check("idle_count", count, 0);

    // 2. fill to full, overflow, drain
    afull_thr = 5'd16;
    for (int i = 0; i < DEPTH; i++) drive(1'b1, DATA'(i), 1'b0, 1'b0);
    check("full_wfull", wfull, 1);
    check("full_count", count, 16);
    check("full_afull", walmost_full, 1);
    check("full_overflow_pre", overflow, 0);
    afull_thr  = 5'd17;
    aempty_thr = 5'd20;
    #1;
    check("thr_above_depth_afull", walmost_full, 0);
    check("thr_above_depth_aempty", ralmost_empty, 1);
    drive(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    check("ovf_wfull", wfull, 1);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, 1'b1, 1'b0);
    check("drain_rempty", rempty, 1);
    check("drain_count", count, 0);
    check("ovf_sticky", overflow, 1);
    idle();
`ifndef SYNC_FIFO_FWFT_EN
    check("rdata_hold", rdata, 8'h0F);
`endif
    drive(1'b0, '0, 1'b0, 1'b1);
    check("ovf_clr", overflow, 0);

    // 3. thresholds
    afull_thr  = 5'd12;
    aempty_thr = 5'd3;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, DATA'(8'h20 + i), 1'b0, 1'b0);
      check("thr_w_count", count, i + 1);
      check("thr_w_afull", walmost_full, (i + 1 >= 12) ? 1 : 0);
      check("thr_w_aempty", ralmost_empty, (i + 1 <= 3) ? 1 : 0);
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      check("thr_r_aempty", ralmost_empty, (11 - i <= 3) ? 1 : 0);
      check("thr_r_afull", walmost_full, (11 - i >= 12) ? 1 : 0);
    end
    check("thr_r_count", count, 3);
    repeat (3) drive(1'b0, '0, 1'b1, 1'b0);

    // 4. simultaneous read/write at count 5, pointers wrap
    for (int i = 0; i < 5; i++) drive(1'b1, DATA'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, DATA'(8'h50 + i), 1'b1, 1'b0);
      check("rw_count", count, int'(m_cnt_p));
    end
    check("rw_count_final", count, 5);
    repeat (5) drive(1'b0, '0, 1'b1, 1'b0);
    check("rw_rempty", rempty, 1);

    // 5. underflow and clear
    drive(1'b0, '0, 1'b1, 1'b0);
    check("udf_set", underflow, 1);
    check("udf_count", count, 0);
    check("udf_rempty", rempty, 1);
    drive(1'b0, '0, 1'b1, 1'b1);
    check("udf_set_wins", underflow, 1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("udf_clr", underflow, 0);

    // 6. mid-operation reset with a concurrent write
    for (int i = 0; i < 7; i++) drive(1'b1, DATA'(8'h60 + i), 1'b0, 1'b0);
    check("pre_rst_count", count, 7);
    rstn = 1'b0;
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    rstn = 1'b1;
    model_reset();
    check("mid_rst_count", count, 0);
    check("mid_rst_rempty", rempty, 1);
`ifndef SYNC_FIFO_FWFT_EN
    check("mid_rst_rdata", rdata, 0);
`endif
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    check("post_rst_count", count, 1);
    check("post_rst_rempty", rempty, 0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_first_word", rdata, 8'hC3);
`endif
    drive(1'b0, '0, 1'b1, 1'b0);
    check("post_rst_drain", rempty, 1);

    repeat (2) idle();
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's FIFO block and uses the same winc/rinc/wdata/rdata/wfull/rempty handshake. Over the current block it adds an occupancy count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. It sits between a producer and a consumer that share one clock domain.

Parameters:
DATA, 8, data width in bits
ADDR, 4, address width; DEPTH = 2**ADDR entries (default 16)

Ports:
clk  input  1  single clock; all logic samples on posedge
rstn  input  1  reset; synchronous, active-low
winc  input  1  write request
wdata  input  DATA  write data
rinc  input  1  read request
afull_thr  input  ADDR+1  almost-full threshold, 0..DEPTH
aempty_thr  input  ADDR+1  almost-empty threshold, 0..DEPTH
clr_err  input  1  one-cycle pulse; clears the sticky error flags
rdata  output  DATA  read data
wfull  output  1  FIFO holds DEPTH entries
rempty  output  1  FIFO holds 0 entries
walmost_full  output  1  count >= afull_thr
ralmost_empty  output  1  count <= aempty_thr
count  output  ADDR+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was attempted while full
underflow  output  1  sticky: a read was attempted while empty

Behaviour:
- Reset: synchronous, active-low; rstn is sampled at posedge clk and takes priority over all other inputs.
- Reset values: wptr=0, rptr=0, count=0, rdata=0, wfull=0, rempty=1, overflow=0, underflow=0.
- After reset, ralmost_empty=1 and walmost_full=(afull_thr==0). Both are combinational from count and the thresholds.
- Memory contents are not reset.
- Pointers are ADDR+1 bits wide; the extra MSB is the wrap bit.
  - Empty: wptr==rptr.
  - Full: the MSBs differ and the low ADDR bits are equal.
- Write accepted when winc && !wfull: mem[wptr[ADDR-1:0]] <= wdata and wptr++ at the same edge. wfull/count update at that edge and are visible the next cycle.
- Read accepted when rinc && !rempty: rptr++. In standard mode, rdata <= mem[rptr] at the same edge, so data is valid the cycle after rinc is sampled. rdata holds its value when no read is accepted.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- When full, a write is always blocked, even with a concurrent accepted read. Producers gate on wfull only.
- When empty, a read is always blocked, even with a concurrent write. The written word becomes readable the next cycle.
- winc && wfull: no pointer or memory change; overflow <= 1.
- rinc && rempty: no change; underflow <= 1.
- clr_err clears overflow/underflow at the next edge. If an error event and clr_err occur in the same cycle, the flag ends up set (set wins).
- count = wptr - rptr using (ADDR+1)-bit modular arithmetic, registered. It is never above DEPTH.
- Thresholds above DEPTH: walmost_full is never asserted; ralmost_empty is always asserted.
- Wrap-around: pointers roll from 2*DEPTH-1 to 0 with no special handling.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined:
  - rdata = mem[rptr[ADDR-1:0]] combinationally whenever !rempty; rinc pops the word currently shown.
  - A word written at edge N appears on rdata in cycle N+1 with rempty=0.
  - rdata is don't-care while rempty=1.
- Undefined: standard registered read as described in Behaviour (one cycle of read latency).
- Flags, count and error behaviour are identical in both modes.

Decomposition:
- Package fifo_pkg:
  - default DATA/ADDR localparams;
  - a typedef for the pointer/count type, logic [ADDR:0];
  - the function depth(addr) = 1<<addr.
- Sub-module fifo_mem: dual-port register array.
  - One synchronous write port (we, waddr, wdata).
  - One read port; registered, or combinational when SYNC_FIFO_FWFT_EN is defined.
  - No reset.
- The top level holds the pointers, count, flags and error logic.

Test Plan:
1. Reset/idle: hold rstn=0 for 3 cycles, then release with all inputs 0 → rempty=1, wfull=0, count=0, overflow=underflow=0, rdata=0.
2. Fill to full: write 0x00..0x0F over 16 cycles (DATA=8, ADDR=4), then one more write of 0xAA.
   - wfull=1 and count=16 after the 16th write.
   - The 17th write sets overflow=1 and is dropped.
   - Draining gives 0x00..0x0F in order, and 0xAA never appears.
3. Thresholds: afull_thr=12, aempty_thr=3.
   - Write 12 words: walmost_full rises the cycle count becomes 12.
   - Read 9 words: ralmost_empty rises when count reaches 3.
4. Simultaneous read and write at count=5 for 20 cycles → count stays 5, the pointers wrap past 31→0, and the data order is preserved.
5. Errors: rinc while empty → underflow=1 with no pointer change.
   - clr_err pulsed together with a new underflow → underflow stays 1.
   - clr_err alone next cycle → underflow=0.
6. Mid-operation reset: with count=7, drive rstn=0 for one cycle together with winc=1 → next cycle count=0, rempty=1, and no write occurred. Repeat the scenario with SYNC_FIFO_FWFT_EN defined and check that rdata shows the first word in the cycle after the write.
